// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
//   Byte-addressed data RAM with byte lanes, load size/extension logic and the MEM/WB
//   pipeline register. It also serves the debug unit: raw word read-out, per-word dirty
//   bit, and a memory clear that runs while i_soft_reset is low (acknowledged on
//   o_soft_reset_ack once every word is zero).
// Optional feature macro: MEM_DIRTY_TRACK_EN (per-word dirty bits; otherwise the dirty
//   output is tied 0).
// Ports:
//   i_clock, i_soft_reset (sync, active low)     clock / reset + clear trigger
//   i_enable_pipeline                             MEM/WB register load enable
//   i_control_write_read_mem                      1 = pipeline writes inhibited
//   i_control_address_mem                         0 = ALU address, 1 = debug address
//   i_enable_mem_datos                            RAM port enable
//   i_rsta, i_regcea                              output register reset/enable (HIGH_PERFORMANCE)
//   i_address_ALU, i_address_debug_unit           addresses
//   i_data_write_mem, i_select_bytes_mem_datos    store data, access size/extension
//   i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_registro_destino, i_halt_detected
//   o_RegWrite, o_MemtoReg, o_registro_destino, o_halt_detected, o_data_alu  MEM/WB register
//   o_data_mem                                    extracted/extended load data
//   o_soft_reset_ack, o_dato_mem_to_debug_unit, o_bit_sucio_to_debug_unit, o_led
module mem_stage #(
  parameter int unsigned RAM_WIDTH                       = 32,
  parameter string       RAM_PERFORMANCE                 = "LOW_LATENCY",
  parameter string       INIT_FILE                       = "",
  parameter int unsigned RAM_DEPTH                       = 1024,
  parameter int unsigned CANT_COLUMNAS_MEM_DATOS         = 4,
  parameter int unsigned CANT_REGISTROS                  = 32,
  parameter int unsigned CANT_BITS_ADDR                  = 12,
  parameter int unsigned CANT_BITS_REGISTROS             = 32,
  parameter int unsigned CANT_BITS_SELECT_BYTES_MEM_DATA = 3
) (
  input  logic                                       i_clock,
  input  logic                                       i_soft_reset,
  input  logic                                       i_enable_pipeline,
  input  logic                                       i_halt_detected,
  input  logic                                       i_control_write_read_mem,
  input  logic                                       i_control_address_mem,
  input  logic                                       i_enable_mem_datos,
  input  logic                                       i_rsta,
  input  logic                                       i_regcea,
  input  logic [CANT_BITS_REGISTROS-1:0]             i_address_ALU,
  input  logic [CANT_BITS_ADDR-1:0]                  i_address_debug_unit,
  input  logic [CANT_BITS_REGISTROS-1:0]             i_data_write_mem,
  input  logic                                       i_RegWrite,
  input  logic                                       i_MemRead,
  input  logic                                       i_MemWrite,
  input  logic                                       i_MemtoReg,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos,
  input  logic [$clog2(CANT_REGISTROS)-1:0]          i_registro_destino,
  output logic                                       o_RegWrite,
  output logic                                       o_MemtoReg,
  output logic [$clog2(CANT_REGISTROS)-1:0]          o_registro_destino,
  output logic                                       o_halt_detected,
  output logic [CANT_BITS_REGISTROS-1:0]             o_data_alu,
  output logic [CANT_BITS_REGISTROS-1:0]             o_data_mem,
  output logic                                       o_soft_reset_ack,
  output logic [RAM_WIDTH-1:0]                       o_dato_mem_to_debug_unit,
  output logic                                       o_bit_sucio_to_debug_unit,
  output logic [2:0]                                 o_led
);

  localparam int unsigned Cols = CANT_COLUMNAS_MEM_DATOS;
  localparam int unsigned ColW = RAM_WIDTH / Cols;
  localparam int unsigned OffW = $clog2(Cols);
  localparam int unsigned AW   = $clog2(RAM_DEPTH);
  localparam int unsigned SelW = CANT_BITS_SELECT_BYTES_MEM_DATA;

  typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

  typedef struct packed {
    logic                 dirty;
    logic [SelW-1:0]      sel;
    logic [OffW-1:0]      off;
    logic [RAM_WIDTH-1:0] word;
  } rd_t;

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];

  // Address decode
  logic [CANT_BITS_ADDR-1:0] addr_mem;
  logic [AW-1:0]             idx;
  logic [OffW-1:0]           off;

  assign addr_mem = i_control_address_mem ? i_address_debug_unit
                                          : i_address_ALU[CANT_BITS_ADDR-1:0];
  assign off      = addr_mem[OffW-1:0];
  assign idx      = addr_mem[OffW +: AW];  // word index wraps modulo RAM_DEPTH

  // Clear FSM
  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (i_soft_reset) begin
      state_d = StIdle;  // release aborts any clear in progress
    end else begin
      case (state_q)
        StIdle: begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
        StClear: begin
          if (clr_addr_q == AW'(RAM_DEPTH - 1)) state_d = StDone;
          else clr_addr_d = clr_addr_q + 1'b1;
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    state_q    <= state_d;
    clr_addr_q <= clr_addr_d;
  end

  logic clr_we, pipe_we;
  assign clr_we  = !i_soft_reset && (state_q == StClear);
  assign pipe_we = i_soft_reset && i_MemWrite && i_enable_mem_datos && !i_control_write_read_mem;

  // Store lane enables and lane-replicated data
  logic [Cols-1:0]      be;
  logic [RAM_WIDTH-1:0] wdata;

  always_comb begin
    be    = '1;
    wdata = i_data_write_mem[RAM_WIDTH-1:0];
    case (i_select_bytes_mem_datos[1:0])
      2'b01: begin
        be      = '0;
        be[off] = 1'b1;
        wdata   = {Cols{i_data_write_mem[ColW-1:0]}};
      end
      2'b10: begin
        be    = {{(Cols/2){off[OffW-1]}}, {(Cols/2){~off[OffW-1]}}};
        wdata = {2{i_data_write_mem[RAM_WIDTH/2-1:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (clr_we) begin
      ram[clr_addr_q] <= '0;
    end else if (pipe_we) begin
      for (int c = 0; c < Cols; c++) begin
        if (be[c]) ram[idx][c*ColW +: ColW] <= wdata[c*ColW +: ColW];
      end
    end
  end

  logic dirty_rd;
`ifdef MEM_DIRTY_TRACK_EN
  logic [RAM_DEPTH-1:0] dirty_q;
  always_ff @(posedge i_clock) begin
    if (clr_we)       dirty_q[clr_addr_q] <= 1'b0;
    else if (pipe_we) dirty_q[idx]        <= 1'b1;
  end
  assign dirty_rd = dirty_q[idx];
`else
  assign dirty_rd = 1'b0;
`endif

  // Read register: the word travels with the size/offset of its own access
  rd_t rd_q, rd_o;

  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      rd_q <= '0;
    end else if (i_enable_mem_datos) begin
      rd_q <= '{dirty: dirty_rd, sel: i_select_bytes_mem_datos, off: off, word: ram[idx]};
    end
  end

  if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_hp
    rd_t rd2_q;
    always_ff @(posedge i_clock) begin
      if (!i_soft_reset || i_rsta) rd2_q <= '0;
      else if (i_regcea)           rd2_q <= rd_q;
    end
    assign rd_o = rd2_q;
  end else begin : g_ll
    logic unused_hp;
    assign unused_hp = ^{i_rsta, i_regcea};
    assign rd_o      = rd_q;
  end

  // Load extraction / extension
  logic [ColW-1:0]        byte_v;
  logic [RAM_WIDTH/2-1:0] half_v;

  always_comb begin
    byte_v     = rd_o.word[rd_o.off*ColW +: ColW];
    half_v     = rd_o.off[OffW-1] ? rd_o.word[RAM_WIDTH-1 -: RAM_WIDTH/2]
                                  : rd_o.word[RAM_WIDTH/2-1:0];
    o_data_mem = rd_o.word;
    case (rd_o.sel[1:0])
      2'b01:   o_data_mem = {{(RAM_WIDTH-ColW){~rd_o.sel[2] & byte_v[ColW-1]}}, byte_v};
      2'b10:   o_data_mem = {{(RAM_WIDTH/2){~rd_o.sel[2] & half_v[RAM_WIDTH/2-1]}}, half_v};
      default: ;
    endcase
  end

  assign o_dato_mem_to_debug_unit = rd_o.word;
`ifdef MEM_DIRTY_TRACK_EN
  assign o_bit_sucio_to_debug_unit = rd_o.dirty;
`else
  logic unused_dirty;
  assign unused_dirty              = rd_o.dirty;
  assign o_bit_sucio_to_debug_unit = 1'b0;
`endif

  // MEM/WB register
  always_ff @(posedge i_clock) begin
    if (!i_soft_reset) begin
      o_RegWrite         <= 1'b0;
      o_MemtoReg         <= 1'b0;
      o_registro_destino <= '0;
      o_halt_detected    <= 1'b0;
      o_data_alu         <= '0;
    end else if (i_enable_pipeline) begin
      o_RegWrite         <= i_RegWrite;
      o_MemtoReg         <= i_MemtoReg;
      o_registro_destino <= i_registro_destino;
      o_halt_detected    <= i_halt_detected;
      o_data_alu         <= i_address_ALU;
    end
  end

  assign o_soft_reset_ack = (state_q == StDone);
  assign o_led            = {o_halt_detected, o_soft_reset_ack, state_q == StClear};

  // Loads read the RAM every enabled cycle, so the MemRead strobe carries no extra meaning
  logic unused_memread;
  assign unused_memread = i_MemRead;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int Depth = 1024;

  logic        clk = 1'b0;
  logic        rst, en_pipe, halt, wr_inh, dsel, en_mem, rsta, regcea;
  logic [31:0] alu, wdat;
  logic [11:0] dbg;
  logic        rw, mr, mw, m2r;
  logic [2:0]  sel;
  logic [4:0]  dst;

  logic        o_rw, o_m2r, o_halt, o_ack, o_dirty;
  logic [4:0]  o_dst;
  logic [31:0] o_alu, o_dmem, o_raw;
  logic [2:0]  o_led;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clock                  (clk),
    .i_soft_reset             (rst),
    .i_enable_pipeline        (en_pipe),
    .i_halt_detected          (halt),
    .i_control_write_read_mem (wr_inh),
    .i_control_address_mem    (dsel),
    .i_enable_mem_datos       (en_mem),
    .i_rsta                   (rsta),
    .i_regcea                 (regcea),
    .i_address_ALU            (alu),
    .i_address_debug_unit     (dbg),
    .i_data_write_mem         (wdat),
    .i_RegWrite               (rw),
    .i_MemRead                (mr),
    .i_MemWrite               (mw),
    .i_MemtoReg               (m2r),
    .i_select_bytes_mem_datos (sel),
    .i_registro_destino       (dst),
    .o_RegWrite               (o_rw),
    .o_MemtoReg               (o_m2r),
    .o_registro_destino       (o_dst),
    .o_halt_detected          (o_halt),
    .o_data_alu               (o_alu),
    .o_data_mem               (o_dmem),
    .o_soft_reset_ack         (o_ack),
    .o_dato_mem_to_debug_unit (o_raw),
    .o_bit_sucio_to_debug_unit(o_dirty),
    .o_led                    (o_led)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: memory image plus the expected output values
  logic [31:0] m_mem [Depth];
  logic        m_dirty [Depth];
  logic        e_rw, e_m2r, e_halt, e_ack, e_dirty;
  logic [4:0]  e_dst;
  logic [31:0] e_alu, e_dmem, e_raw;
  logic [2:0]  e_led;
  int          rst_cnt = 0;
  bit          started = 0;

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] s,
                                           input logic [1:0] o);
    logic [31:0] sh;
    if (s[1:0] == 2'b01) begin
      sh = w >> (8 * o);
      return s[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end
    if (s[1:0] == 2'b10) begin
      sh = o[1] ? (w >> 16) : w;
      return s[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
    return w;
  endfunction

  initial begin
    for (int i = 0; i < Depth; i++) begin
      m_mem[i]   = '0;
      m_dirty[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    logic [11:0] a;
    int          wi;
    a  = dsel ? dbg : alu[11:0];
    wi = int'(a[11:2]);
    if (!rst) begin
      started = 1;
      rst_cnt++;
      // First low edge starts the clear; each later edge zeroes one word in order
      if (rst_cnt >= 2 && rst_cnt <= Depth + 1) begin
        m_mem[rst_cnt-2]   = '0;
        m_dirty[rst_cnt-2] = 1'b0;
      end
      {e_rw, e_m2r, e_halt, e_dst, e_alu, e_dmem, e_raw, e_dirty} = '0;
    end else begin
      rst_cnt = 0;
      if (en_mem) begin
        e_raw   = m_mem[wi];
        e_dirty = m_dirty[wi];
        e_dmem  = load_val(m_mem[wi], sel, a[1:0]);
      end
      if (mw && en_mem && !wr_inh) begin
        case (sel[1:0])
          2'b01:   m_mem[wi][8*a[1:0] +: 8] = wdat[7:0];
          2'b10:   m_mem[wi][16*a[1] +: 16] = wdat[15:0];
          default: m_mem[wi] = wdat;
        endcase
        m_dirty[wi] = 1'b1;
      end
      if (en_pipe) begin
        e_rw   = rw;
        e_m2r  = m2r;
        e_dst  = dst;
        e_halt = halt;
        e_alu  = alu;
      end
    end
    e_ack = (rst_cnt >= Depth + 1);
    e_led = {e_halt, e_ack, (rst_cnt >= 1 && rst_cnt <= Depth)};
  end

  // Compare process: every cycle once the first reset edge has been seen
  always @(negedge clk) begin
    if (started) begin
      chk("regwrite", 32'(o_rw), 32'(e_rw));
      chk("memtoreg", 32'(o_m2r), 32'(e_m2r));
      chk("dest", 32'(o_dst), 32'(e_dst));
      chk("halt", 32'(o_halt), 32'(e_halt));
      chk("data_alu", o_alu, e_alu);
      chk("data_mem", o_dmem, e_dmem);
      chk("raw_word", o_raw, e_raw);
`ifdef MEM_DIRTY_TRACK_EN
      chk("dirty", 32'(o_dirty), 32'(e_dirty));
`else
      chk("dirty", 32'(o_dirty), 32'd0);
`endif
      chk("ack", 32'(o_ack), 32'(e_ack));
      chk("led", 32'(o_led), 32'(e_led));
    end
  end

  // Drive one cycle of stimulus, return after the next falling edge
  task automatic drive(input logic we, input logic [2:0] s, input logic [11:0] addr,
                       input logic [31:0] d, input logic inh, input logic ds,
                       input logic pipe, input logic r, input logic [4:0] de);
    mw = we; sel = s; alu = {20'h0, addr}; dbg = addr; wdat = d; wr_inh = inh;
    dsel = ds; en_pipe = pipe; rw = r; dst = de; en_mem = 1'b1; mr = ~we;
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    logic [9:0] wi;
    wi      = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
    alu     = {$urandom_range(0, 255), 12'h0} | {20'h0, wi, 2'($urandom)};
    dbg     = {wi, 2'($urandom)};
    dsel    = ($urandom_range(0, 4) == 0);
    wdat    = $urandom;
    sel     = 3'($urandom);
    mw      = $urandom_range(0, 1);
    mr      = $urandom_range(0, 1);
    wr_inh  = ($urandom_range(0, 4) == 0);
    en_mem  = ($urandom_range(0, 6) != 0);
    en_pipe = ($urandom_range(0, 4) != 0);
    rw      = $urandom_range(0, 1);
    m2r     = $urandom_range(0, 1);
    halt    = ($urandom_range(0, 7) == 0);
    dst     = 5'($urandom);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en_pipe = 0; halt = 0; wr_inh = 0; dsel = 0; en_mem = 0; rsta = 0;
    regcea = 1'b1; alu = '0; wdat = '0; dbg = '0; rw = 0; mr = 0; mw = 0; m2r = 0;
    sel = '0; dst = '0;
    repeat (2) @(negedge clk);

    // Full clear
    rst = 1'b0;
    @(negedge clk);
    chk("lit_led_clearing", 32'(o_led), 32'h1);
    chk("lit_ack_early", 32'(o_ack), 32'h0);
    repeat (Depth) @(negedge clk);
    chk("lit_ack_done", 32'(o_ack), 32'h1);
    chk("lit_led_done", 32'(o_led), 32'h2);
    chk("lit_dmem_reset", o_dmem, 32'h0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_ack_release", 32'(o_ack), 32'h0);

    // Directed loads/stores
    drive(1, 3'b000, 12'd8, 32'hFFDECBAA, 0, 0, 1, 0, 5'd0);
    drive(0, 3'b000, 12'd8, 32'h0, 0, 0, 1, 0, 5'd0);
    chk("lit_lw8", o_dmem, 32'hFFDECBAA);
`ifdef MEM_DIRTY_TRACK_EN
    chk("lit_dirty8", 32'(o_dirty), 32'h1);
`endif
    drive(1, 3'b001, 12'd9, 32'h123456AA, 0, 0, 1, 0, 5'd0);
    drive(0, 3'b000, 12'd8, 32'h0, 0, 0, 1, 0, 5'd0);
    chk("lit_sb_word", o_dmem, 32'hFFDEAAAA);
    drive(0, 3'b001, 12'd9, 32'h0, 0, 0, 1, 0, 5'd0);
    chk("lit_lb9", o_dmem, 32'hFFFFFFAA);
    drive(0, 3'b101, 12'd9, 32'h0, 0, 0, 1, 0, 5'd0);
    chk("lit_lbu9", o_dmem, 32'h000000AA);
    drive(1, 3'b010, 12'd10, 32'h00001234, 0, 0, 1, 0, 5'd0);
    drive(0, 3'b000, 12'd8, 32'h0, 0, 0, 1, 0, 5'd0);
    chk("lit_sh_word", o_dmem, 32'h1234AAAA);
    drive(0, 3'b010, 12'd10, 32'h0, 0, 0, 1, 0, 5'd0);
    chk("lit_lh10", o_dmem, 32'h00001234);
    drive(1, 3'b000, 12'd8, 32'hDEADBEEF, 1, 0, 1, 0, 5'd0);
    drive(0, 3'b000, 12'd8, 32'h0, 0, 1, 1, 0, 5'd0);
    chk("lit_debug_raw", o_raw, 32'h1234AAAA);

    // Stall then release
    drive(0, 3'b000, 12'd0, 32'h0, 0, 0, 1, 0, 5'd0);
    repeat (3) begin
      drive(0, 3'b000, 12'd0, 32'h0, 0, 0, 0, 1, 5'd5);
      chk("lit_stall_hold", 32'(o_rw), 32'h0);
    end
    drive(0, 3'b000, 12'd0, 32'h0, 0, 0, 1, 1, 5'd5);
    chk("lit_release_rw", 32'(o_rw), 32'h1);
    chk("lit_release_dst", 32'(o_dst), 32'd5);

    // Random traffic with occasional short resets that abort the clear
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 40)) rand_cycle();
        rst = 1'b1;
      end
      rand_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
